lane_sweep_counter: RTL

- Parametrised successor of the flat step counter; sweeps the (x, y, z) coordinates of the permutation state in nested order: z fastest, then x, then y.
- Has a programmable z terminal count, run/done control and per-level carry flags, where the old counter had only a fixed terminal count of 64.
- Drives state-array addressing in the permutation datapath controller. One instance per sweep (theta/rho/pi passes).

---
 rtl/permutation_pkg.sv | 14 +
 rtl/lane_sweep_counter_if.sv | 30 +++
 rtl/lane_sweep_counter_wrap_counter.sv | 28 ++
 rtl/lane_sweep_counter.sv | 93 +++++++++
 4 files changed

// File: rtl/permutation_pkg.sv
// rtl/permutation_pkg.sv - shared sizes and sweep state type for the permutation datapath
package permutation_pkg;

  localparam int X_MAX_DEF = 5;
  localparam int Y_MAX_DEF = 5;
  localparam int Z_MAX_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lane_sweep_counter_if.sv
// rtl/lane_sweep_counter_if.sv - control and index bundle of the lane sweep counter
interface lane_sweep_counter_if #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int ZW = 7,
  parameter int FW = 11
);
  logic          init;
  logic [ZW-1:0] z_lim;
  logic          inc;
  logic [XW-1:0] x_idx;
  logic [YW-1:0] y_idx;
  logic [ZW-1:0] z_idx;
  logic [FW-1:0] flat_idx;
  logic          started;
  logic          z_co;
  logic          x_co;
  logic          busy;
  logic          done;

  modport master (
    output init, z_lim, inc,
    input  x_idx, y_idx, z_idx, flat_idx, started, z_co, x_co, busy, done
  );

  modport slave (
    input  init, z_lim, inc,
    output x_idx, y_idx, z_idx, flat_idx, started, z_co, x_co, busy, done
  );
endinterface

// File: rtl/lane_sweep_counter_wrap_counter.sv
// rtl/lane_sweep_counter_wrap_counter.sv - single-level index counter wrapping at a limit
module wrap_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   limit,
  output logic [W-1:0] out,
  output logic         last
);

  // limit is a position count, so the top index is limit-1; one extra bit lets limit itself fit
  assign last = ({1'b0, out} == (limit - 1'b1));

  // advance on enable, wrap to zero after the top index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (en) begin
      out <= last ? '0 : out + 1'b1;
    end
  end

endmodule

// File: rtl/lane_sweep_counter.sv
// rtl/lane_sweep_counter.sv - nested (z, x, y) sweep counter with run/done control
module lane_sweep_counter
  import permutation_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int Z_MAX = Z_MAX_DEF,
  parameter int XW    = $clog2(X_MAX),
  parameter int YW    = $clog2(Y_MAX),
  parameter int ZW    = $clog2(Z_MAX) + 1,
  parameter int FW    = $clog2(X_MAX * Y_MAX * Z_MAX)
) (
  input  logic clk,
  input  logic rst_n,
  lane_sweep_counter_if.slave bus
);

  state_t        state_q, state_d;
  logic [ZW-1:0] zl_q;
  logic [FW-1:0] flat_q;
  logic          started_q;
  logic          done_q;
  logic          step;
  logic          z_last, x_last, y_last;
  logic          final_step;

  // init always wins over inc, so a same-cycle inc is dropped
  assign step       = (state_q == RUN) && bus.inc && !bus.init;
  assign final_step = z_last && x_last && y_last;

  wrap_counter #(.W(ZW)) u_z (
    .clk(clk), .rst_n(rst_n), .clr(bus.init), .en(step),
    .limit({1'b0, zl_q}), .out(bus.z_idx), .last(z_last)
  );

  wrap_counter #(.W(XW)) u_x (
    .clk(clk), .rst_n(rst_n), .clr(bus.init), .en(step && z_last),
    .limit((XW + 1)'(X_MAX)), .out(bus.x_idx), .last(x_last)
  );

  wrap_counter #(.W(YW)) u_y (
    .clk(clk), .rst_n(rst_n), .clr(bus.init), .en(step && z_last && x_last),
    .limit((YW + 1)'(Y_MAX)), .out(bus.y_idx), .last(y_last)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: init restarts from anywhere, the final step parks in DONE
  always_comb begin
    state_d = state_q;
    if (bus.init) begin
      state_d = RUN;
    end else if (step && final_step) begin
      state_d = DONE;
    end
  end

  // lane length latch, flat position, started flag and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zl_q      <= ZW'(Z_MAX);
      flat_q    <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.init) begin
      zl_q      <= ((bus.z_lim == '0) || (bus.z_lim > ZW'(Z_MAX))) ? ZW'(Z_MAX) : bus.z_lim;
      flat_q    <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= step && final_step;
      if (step) begin
        flat_q    <= final_step ? '0 : flat_q + 1'b1;
        started_q <= 1'b1;
      end
    end
  end

  assign bus.flat_idx = flat_q;
  assign bus.started  = started_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.z_co     = z_last;
  assign bus.x_co     = z_last && x_last;

endmodule
